// File: rtl/nb_pkg.sv
`default_nettype none
// ============================================================================
// Module      : nb_pkg
// Description : Types, constants and the vector element-slice helper that the
//               backprop decode stages share.
// Revision    : 1.0 - initial release
// ============================================================================
package nb_pkg;

    typedef enum logic [0:0] {
        IDLE = 1'b0,
        EMIT = 1'b1
    } decode_state_t;

    localparam int INDEX_W    = 32;

    // Upper bounds on packed vector and element width that the slice helper supports
    localparam int VEC_MAX_W  = 4096;
    localparam int ELEM_MAX_W = 64;

    typedef logic [VEC_MAX_W-1:0]  vec_max_t;
    typedef logic [ELEM_MAX_W-1:0] elem_max_t;

    function automatic elem_max_t elem_slice(
        input vec_max_t           vec,
        input logic [INDEX_W-1:0] idx,
        input int unsigned        width
    );
        return elem_max_t'(vec >> (idx * width));
    endfunction

endpackage : nb_pkg
`default_nettype wire

// File: rtl/relu_grad_gate.sv
`default_nettype none
// ============================================================================
// Module      : relu_grad_gate
// Description : ReLU derivative gate: passes the error when signed z > 0.
// Revision    : 1.0 - initial release
// ============================================================================
module relu_grad_gate #(
    parameter int DATA_W = 16
) (
    input  logic [DATA_W-1:0] i_error,
    input  logic [DATA_W-1:0] i_z,
    output logic [DATA_W-1:0] o_delta
);

    logic w_z_pos;

    assign w_z_pos = ($signed(i_z) > $signed({DATA_W{1'b0}}));
    assign o_delta = w_z_pos ? i_error : '0;

endmodule : relu_grad_gate
`default_nettype wire

// File: rtl/decode_delta_unit.sv
`default_nettype none
// ============================================================================
// Module      : decode_delta_unit
// Description : Captures error/pre-activation vectors and streams ReLU-gated
//               per-neuron deltas with layer/row/column tags.
// Revision    : 1.0 - initial release
// ============================================================================
module decode_delta_unit
    import nb_pkg::*;
#(
    parameter int size      = 3,
    parameter int data_size = 16
) (
    input  logic                        clk,
    input  logic                        rst_n,
    input  logic [data_size*size-1:0]   predict_value,
    input  logic [data_size*size-1:0]   z,
    input  logic [INDEX_W-1:0]          w_layer_index,
    input  logic [INDEX_W-1:0]          w_row_index,
    input  logic                        update_weight,
    input  logic                        delta_ready,
    input  logic                        clear_overrun,
    output logic [data_size-1:0]        delta_out,
    output logic [INDEX_W-1:0]          col_index_out,
    output logic [INDEX_W-1:0]          w_layer_index_out,
    output logic [INDEX_W-1:0]          w_row_index_out,
    output logic                        delta_valid,
    output logic                        delta_last,
    output logic                        busy,
    output logic                        overrun
);

    typedef logic [data_size-1:0] elem_t;

    localparam logic [INDEX_W-1:0] c_LAST_COL = INDEX_W'(size - 1);

    decode_state_t               r_state;
    decode_state_t               w_state_next;
    logic [data_size*size-1:0]   r_pred;
    logic [data_size*size-1:0]   r_z;
    logic [INDEX_W-1:0]          r_layer;
    logic [INDEX_W-1:0]          r_row;
    logic [INDEX_W-1:0]          r_col;
    logic                        r_overrun;

    logic                        w_emit;
    logic                        w_at_last;
    logic                        w_hs;
    logic                        w_final_hs;
    logic                        w_start;
    logic                        w_drop;
    elem_t                       w_pred_elem;
    elem_t                       w_z_elem;

    assign w_emit     = (r_state == EMIT);
    assign w_at_last  = (r_col == c_LAST_COL);
    assign w_hs       = w_emit & delta_ready;
    assign w_final_hs = w_hs & w_at_last;
    // A start is only taken when the current vector is done or finishing this cycle
    assign w_start    = update_weight & (~w_emit | w_final_hs);
    assign w_drop     = update_weight & w_emit & ~w_final_hs;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state <= IDLE;
        end else begin
            r_state <= w_state_next;
        end
    end

    always_comb begin
        w_state_next = r_state;
        case (r_state)
            IDLE: if (w_start) w_state_next = EMIT;
            EMIT: if (w_final_hs && !w_start) w_state_next = IDLE;
            default: w_state_next = IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_pred    <= '0;
            r_z       <= '0;
            r_layer   <= '0;
            r_row     <= '0;
            r_col     <= '0;
            r_overrun <= 1'b0;
        end else begin
            if (w_start) begin
                r_pred  <= predict_value;
                r_z     <= z;
                r_layer <= w_layer_index;
                r_row   <= w_row_index;
                r_col   <= '0;
            end else if (w_hs) begin
                r_col   <= r_col + 1'b1;
            end
            if (w_drop) begin
                r_overrun <= 1'b1;
            end else if (clear_overrun) begin
                r_overrun <= 1'b0;
            end
        end
    end

    assign w_pred_elem = elem_t'(elem_slice(vec_max_t'(r_pred), r_col, data_size));
    assign w_z_elem    = elem_t'(elem_slice(vec_max_t'(r_z),    r_col, data_size));

    relu_grad_gate #(
        .DATA_W (data_size)
    ) u_gate (
        .i_error (w_pred_elem),
        .i_z     (w_z_elem),
        .o_delta (delta_out)
    );

    assign col_index_out     = r_col;
    assign w_layer_index_out = r_layer;
    assign w_row_index_out   = r_row;
    assign delta_valid       = w_emit;
    assign delta_last        = w_emit & w_at_last;
    assign busy              = w_emit;
    assign overrun           = r_overrun;

endmodule : decode_delta_unit
`default_nettype wire

// File: tb/tb_decode_delta_unit.sv
`default_nettype none
// ============================================================================
// Module      : tb_decode_delta_unit
// Description : Directed self-checking bench for decode_delta_unit (size=3, 16-bit).
// Revision    : 1.0 - initial release
// ============================================================================
module tb_decode_delta_unit;

    logic        clk;
    logic        rst_n;
    logic [47:0] predict_value;
    logic [47:0] z;
    logic [31:0] w_layer_index;
    logic [31:0] w_row_index;
    logic        update_weight;
    logic        delta_ready;
    logic        clear_overrun;
    logic [15:0] delta_out;
    logic [31:0] col_index_out;
    logic [31:0] w_layer_index_out;
    logic [31:0] w_row_index_out;
    logic        delta_valid;
    logic        delta_last;
    logic        busy;
    logic        overrun;

    int n_checks;
    int n_fail;

    logic [47:0] pa;
    logic [47:0] za;
    logic [15:0] exp_a [3];
    logic [47:0] pb;
    logic [47:0] zb;
    logic [15:0] exp_b [3];

    decode_delta_unit #(
        .size      (3),
        .data_size (16)
    ) dut (
        .clk               (clk),
        .rst_n             (rst_n),
        .predict_value     (predict_value),
        .z                 (z),
        .w_layer_index     (w_layer_index),
        .w_row_index       (w_row_index),
        .update_weight     (update_weight),
        .delta_ready       (delta_ready),
        .clear_overrun     (clear_overrun),
        .delta_out         (delta_out),
        .col_index_out     (col_index_out),
        .w_layer_index_out (w_layer_index_out),
        .w_row_index_out   (w_row_index_out),
        .delta_valid       (delta_valid),
        .delta_last        (delta_last),
        .busy              (busy),
        .overrun           (overrun)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Inputs change and outputs are sampled on the falling edge
    task automatic drive_start(input logic [47:0] p, input logic [47:0] zz,
                               input logic [31:0] layer, input logic [31:0] row);
        predict_value = p;
        z             = zz;
        w_layer_index = layer;
        w_row_index   = row;
        update_weight = 1'b1;
    endtask

    task automatic drop_start();
        update_weight = 1'b0;
        predict_value = 48'hDEAD_BEEF_CAFE;
        z             = 48'h1111_1111_1111;
        w_layer_index = 32'hFFFF_FFFF;
        w_row_index   = 32'hEEEE_EEEE;
    endtask

    task automatic test_reset();
        rst_n = 1'b0;
        #1;
        n_checks++;
        if ({delta_valid, delta_last, busy, overrun} !== 4'b0000) begin
            n_fail++;
            $display("FAIL reset_flags: got %b want 0000", {delta_valid, delta_last, busy, overrun});
        end
        n_checks++;
        if ({delta_out, col_index_out, w_layer_index_out, w_row_index_out} !== 112'd0) begin
            n_fail++;
            $display("FAIL reset_data: got d=%h c=%0d l=%0d r=%0d want all 0",
                     delta_out, col_index_out, w_layer_index_out, w_row_index_out);
        end
        @(negedge clk);
        rst_n = 1'b1;
    endtask

    task automatic test_single();
        @(negedge clk);
        drive_start(pa, za, 32'd2, 32'd7);
        delta_ready = 1'b1;
        for (int i = 0; i < 3; i++) begin
            @(negedge clk);
            if (i == 0) drop_start();
            n_checks++;
            if ({delta_valid, busy, delta_last} !== {1'b1, 1'b1, (i == 2)} ||
                delta_out !== exp_a[i] || col_index_out !== 32'(i) ||
                w_layer_index_out !== 32'd2 || w_row_index_out !== 32'd7) begin
                n_fail++;
                $display("FAIL single_beat%0d: got v=%b b=%b l=%b d=%h c=%0d L=%0d R=%0d want v=1 b=1 l=%0d d=%h c=%0d L=2 R=7",
                         i, delta_valid, busy, delta_last, delta_out, col_index_out,
                         w_layer_index_out, w_row_index_out, (i == 2), exp_a[i], i);
            end
        end
        @(negedge clk);
        n_checks++;
        if ({delta_valid, busy} !== 2'b00) begin
            n_fail++;
            $display("FAIL single_idle: got v=%b b=%b want 0 0", delta_valid, busy);
        end
    endtask

    task automatic test_backpressure();
        @(negedge clk);
        drive_start(pa, za, 32'd2, 32'd7);
        delta_ready = 1'b1;
        @(negedge clk);
        drop_start();
        @(negedge clk);
        delta_ready = 1'b0;
        for (int k = 0; k < 4; k++) begin
            @(negedge clk);
            n_checks++;
            if (delta_valid !== 1'b1 || delta_last !== 1'b0 || delta_out !== 16'h0000 ||
                col_index_out !== 32'd1 || w_layer_index_out !== 32'd2) begin
                n_fail++;
                $display("FAIL bp_hold%0d: got v=%b l=%b d=%h c=%0d L=%0d want v=1 l=0 d=0000 c=1 L=2",
                         k, delta_valid, delta_last, delta_out, col_index_out, w_layer_index_out);
            end
        end
        delta_ready = 1'b1;
        @(negedge clk);
        n_checks++;
        if (delta_valid !== 1'b1 || delta_last !== 1'b1 || delta_out !== 16'h0003 ||
            col_index_out !== 32'd2) begin
            n_fail++;
            $display("FAIL bp_resume: got v=%b l=%b d=%h c=%0d want v=1 l=1 d=0003 c=2",
                     delta_valid, delta_last, delta_out, col_index_out);
        end
        @(negedge clk);
        n_checks++;
        if (busy !== 1'b0) begin
            n_fail++;
            $display("FAIL bp_idle: got busy=%b want 0", busy);
        end
    endtask

    task automatic test_back_to_back();
        @(negedge clk);
        drive_start(pa, za, 32'd2, 32'd7);
        delta_ready = 1'b1;
        @(negedge clk);
        drop_start();
        @(negedge clk);
        @(negedge clk);
        drive_start(pb, zb, 32'd3, 32'd9);
        for (int i = 0; i < 3; i++) begin
            @(negedge clk);
            if (i == 0) drop_start();
            n_checks++;
            if (delta_valid !== 1'b1 || delta_out !== exp_b[i] || col_index_out !== 32'(i) ||
                w_layer_index_out !== 32'd3 || w_row_index_out !== 32'd9 || overrun !== 1'b0) begin
                n_fail++;
                $display("FAIL b2b_beat%0d: got v=%b d=%h c=%0d L=%0d R=%0d ov=%b want v=1 d=%h c=%0d L=3 R=9 ov=0",
                         i, delta_valid, delta_out, col_index_out, w_layer_index_out,
                         w_row_index_out, overrun, exp_b[i], i);
            end
        end
        @(negedge clk);
        n_checks++;
        if (busy !== 1'b0) begin
            n_fail++;
            $display("FAIL b2b_idle: got busy=%b want 0", busy);
        end
    endtask

    task automatic test_overrun();
        @(negedge clk);
        drive_start(pa, za, 32'd2, 32'd7);
        delta_ready = 1'b1;
        @(negedge clk);
        drop_start();
        @(negedge clk);
        drive_start(pb, zb, 32'd5, 32'd5);
        @(negedge clk);
        drop_start();
        n_checks++;
        if (overrun !== 1'b1 || delta_valid !== 1'b1 || delta_last !== 1'b1 ||
            delta_out !== 16'h0003 || col_index_out !== 32'd2 || w_layer_index_out !== 32'd2) begin
            n_fail++;
            $display("FAIL ovr_set: got ov=%b v=%b l=%b d=%h c=%0d L=%0d want ov=1 v=1 l=1 d=0003 c=2 L=2",
                     overrun, delta_valid, delta_last, delta_out, col_index_out, w_layer_index_out);
        end
        @(negedge clk);
        n_checks++;
        if (busy !== 1'b0 || overrun !== 1'b1) begin
            n_fail++;
            $display("FAIL ovr_sticky: got busy=%b ov=%b want 0 1", busy, overrun);
        end
        clear_overrun = 1'b1;
        @(negedge clk);
        clear_overrun = 1'b0;
        n_checks++;
        if (overrun !== 1'b0) begin
            n_fail++;
            $display("FAIL ovr_clear: got ov=%b want 0", overrun);
        end
    endtask

    task automatic test_reset_mid();
        @(negedge clk);
        drive_start(pa, za, 32'd2, 32'd7);
        delta_ready = 1'b1;
        @(negedge clk);
        drop_start();
        @(negedge clk);
        rst_n = 1'b0;
        #1;
        n_checks++;
        if ({delta_valid, delta_last, busy, overrun} !== 4'b0000 ||
            {delta_out, col_index_out, w_layer_index_out, w_row_index_out} !== 112'd0) begin
            n_fail++;
            $display("FAIL rst_mid: got v=%b l=%b b=%b ov=%b d=%h c=%0d L=%0d R=%0d want all 0",
                     delta_valid, delta_last, busy, overrun, delta_out, col_index_out,
                     w_layer_index_out, w_row_index_out);
        end
        @(negedge clk);
        rst_n = 1'b1;
    endtask

    task automatic test_signed_boundary();
        logic [15:0] exp_s [3];
        exp_s[0] = 16'h0000;
        exp_s[1] = 16'h8000;
        exp_s[2] = 16'h0000;
        @(negedge clk);
        drive_start({16'h7FFF, 16'h8000, 16'h1234}, {16'hFFFF, 16'h7FFF, 16'h8000}, 32'd1, 32'd1);
        delta_ready = 1'b1;
        for (int i = 0; i < 3; i++) begin
            @(negedge clk);
            if (i == 0) drop_start();
            n_checks++;
            if (delta_valid !== 1'b1 || delta_out !== exp_s[i] || col_index_out !== 32'(i)) begin
                n_fail++;
                $display("FAIL signed_beat%0d: got v=%b d=%h c=%0d want v=1 d=%h c=%0d",
                         i, delta_valid, delta_out, col_index_out, exp_s[i], i);
            end
        end
        @(negedge clk);
    endtask

    initial begin
        n_checks      = 0;
        n_fail        = 0;
        pa            = {16'h0003, 16'hFFFE, 16'h0010};
        za            = {16'h0001, 16'h0000, 16'h0005};
        exp_a[0]      = 16'h0010;
        exp_a[1]      = 16'h0000;
        exp_a[2]      = 16'h0003;
        pb            = {16'h0300, 16'h0200, 16'h0100};
        zb            = {16'h0001, 16'h0002, 16'h0003};
        exp_b[0]      = 16'h0100;
        exp_b[1]      = 16'h0200;
        exp_b[2]      = 16'h0300;
        rst_n         = 1'b0;
        predict_value = '0;
        z             = '0;
        w_layer_index = '0;
        w_row_index   = '0;
        update_weight = 1'b0;
        delta_ready   = 1'b0;
        clear_overrun = 1'b0;
        @(negedge clk);
        test_reset();
        test_single();
        test_backpressure();
        test_back_to_back();
        test_overrun();
        test_reset_mid();
        test_single();
        test_signed_boundary();
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule : tb_decode_delta_unit
`default_nettype wire
